port_in_x8: RTL and testbench

- Input-direction counterpart of the PORTB output driver in the PIC16F84 model.
- Samples the 8 external pins through a synchronizer and returns a registered read value to the core on a port read.
- Generates the two PORTB interrupt flags:
  - RBIF: change-on-input for bits 7:4.
  - INTF: edge on RB0/INT.
- Sits between the pin models and the SFR/interrupt logic.

---
 rtl/port_in_x8.sv | 108 ++++++++++
 tb/tb_port_in_x8.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/port_in_x8.sv
// port_in_x8: PORTB input path with a two-flop pin synchronizer, a registered port read,
// and the RBIF change and INTF edge flags. PORT_IN_GLITCH_FILTER_EN adds a per-bit stability filter.
module port_in_x8 #(
  parameter int WIDTH         = 8,
  parameter int FILTER_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pin_in,
  input  logic [WIDTH-1:0] tris_stat,
  input  logic [WIDTH-1:0] data_latch,
  input  logic             rd_en,
  input  logic             intedg,
  input  logic             rbif_clr,
  input  logic             intf_clr,
  output logic [WIDTH-1:0] rd_data,
  output logic             rbif,
  output logic             intf
);

  if (WIDTH != 8 || FILTER_CYCLES < 1) begin : g_cfg_check
    $error("port_in_x8: WIDTH must be 8 and FILTER_CYCLES must be at least 1");
  end

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] f;
  logic [WIDTH-1:0] s_prev;
  logic [7:4]       cmp_latch;
  logic             primed;
  logic             mismatch;
  logic             int_event;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= pin_in;
      s2 <= s1;
    end
  end

`ifdef PORT_IN_GLITCH_FILTER_EN
  localparam int CW = $clog2(FILTER_CYCLES + 1);

  logic [CW-1:0]    cnt [WIDTH];
  logic [WIDTH-1:0] f_q;

  // A bit only follows s2 after it has disagreed with f for FILTER_CYCLES clocks in a row.
  always_ff @(posedge clk) begin
    if (rst) begin
      f_q <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (s2[i] == f_q[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(FILTER_CYCLES - 1)) begin
          f_q[i] <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign f = f_q;
`else
  assign f = s2;
`endif

  // Compare against the latch as it stood before any read this cycle.
  always_comb begin
    mismatch  = |(tris_stat[7:4] & (f[7:4] ^ cmp_latch));
    int_event = tris_stat[0] & (intedg ? (f[0] & ~s_prev[0]) : (~f[0] & s_prev[0]));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_prev    <= '0;
      rd_data   <= '0;
      cmp_latch <= '0;
      primed    <= 1'b0;
      rbif      <= 1'b0;
      intf      <= 1'b0;
    end else begin
      s_prev <= f;
      if (rd_en) begin
        rd_data   <= (tris_stat & f) | (~tris_stat & data_latch);
        cmp_latch <= f[7:4];
        primed    <= 1'b1;
      end
      if (primed && mismatch) begin
        rbif <= 1'b1;
      end else if (rbif_clr) begin
        rbif <= 1'b0;
      end
      if (int_event) begin
        intf <= 1'b1;
      end else if (intf_clr) begin
        intf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_port_in_x8.sv
// Bench for port_in_x8: directed stimulus, a history-based reference model checked every cycle,
// and literal expectations at the key points. Honours PORT_IN_GLITCH_FILTER_EN when defined.
module tb_port_in_x8;

`ifdef PORT_IN_GLITCH_FILTER_EN
  localparam int XL = 3;
`else
  localparam int XL = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pin_in = 8'h00;
  logic [7:0] tris_stat = 8'h00;
  logic [7:0] data_latch = 8'h00;
  logic       rd_en = 1'b0;
  logic       intedg = 1'b0;
  logic       rbif_clr = 1'b0;
  logic       intf_clr = 1'b0;
  logic [7:0] rd_data;
  logic       rbif;
  logic       intf;

  always #5 clk = ~clk;

  port_in_x8 #(.WIDTH(8), .FILTER_CYCLES(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .pin_in     (pin_in),
    .tris_stat  (tris_stat),
    .data_latch (data_latch),
    .rd_en      (rd_en),
    .intedg     (intedg),
    .rbif_clr   (rbif_clr),
    .intf_clr   (intf_clr),
    .rd_data    (rd_data),
    .rbif       (rbif),
    .intf       (intf)
  );

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 0;

  task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pin history gives the synchronized view; the filter is a window over it.
  logic [7:0] q[$];
  logic [7:0] sh[$];
  logic [7:0] m_f, m_fprev, m_rd, m_cmp;
  bit         m_primed, m_rbif, m_intf;

  always @(posedge clk) begin : model
    logic [7:0] nf;
    bit mis;
    bit ev;
    if (rst) begin
      q.delete();
      q.push_back(8'h00);
      q.push_back(8'h00);
      sh.delete();
      m_f = 8'h00; m_fprev = 8'h00; m_rd = 8'h00; m_cmp = 8'h00;
      m_primed = 0; m_rbif = 0; m_intf = 0;
    end else begin
      mis = 0;
      for (int b = 4; b < 8; b++)
        if (tris_stat[b] && (m_f[b] != m_cmp[b])) mis = 1;
      ev = tris_stat[0] && (m_f[0] != m_fprev[0]) && (m_f[0] == intedg);
      if (m_primed && mis) m_rbif = 1;
      else if (rbif_clr) m_rbif = 0;
      if (ev) m_intf = 1;
      else if (intf_clr) m_intf = 0;
      if (rd_en) begin
        for (int b = 0; b < 8; b++) m_rd[b] = tris_stat[b] ? m_f[b] : data_latch[b];
        m_cmp = m_f;
        m_primed = 1;
      end
      nf = m_f;
`ifdef PORT_IN_GLITCH_FILTER_EN
      sh.push_back(q[0]);
      while (sh.size() > 3) void'(sh.pop_front());
      if (sh.size() == 3)
        for (int b = 0; b < 8; b++)
          if (sh[0][b] != m_f[b] && sh[1][b] != m_f[b] && sh[2][b] != m_f[b]) nf[b] = ~m_f[b];
`endif
      q.push_back(pin_in);
      while (q.size() > 2) void'(q.pop_front());
`ifndef PORT_IN_GLITCH_FILTER_EN
      nf = q[0];
`endif
      m_fprev = m_f;
      m_f = nf;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("model rd_data", rd_data, m_rd);
      cmp("model rbif", {7'b0, rbif}, {7'b0, m_rbif});
      cmp("model intf", {7'b0, intf}, {7'b0, m_intf});
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_rd();
    rd_en = 1'b1; cyc(1); rd_en = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(2);
    rst = 1'b0;
    chk_en = 1;
    cmp("reset rd_data", rd_data, 8'h00);
    cmp("reset rbif", {7'b0, rbif}, 8'h00);
    cmp("reset intf", {7'b0, intf}, 8'h00);

    // all-input read
    pin_in = 8'hA5; tris_stat = 8'hFF; intedg = 1'b0;
    cyc(3 + XL); pulse_rd();
    cmp("read all inputs", rd_data, 8'hA5);
    cmp("read rbif", {7'b0, rbif}, 8'h00);
    cmp("read intf", {7'b0, intf}, 8'h00);

    // mixed direction read
    tris_stat = 8'h0F; data_latch = 8'h30; pin_in = 8'hC9;
    cyc(3 + XL); pulse_rd();
    cmp("read mixed", rd_data, 8'h39);
    cmp("mixed rbif", {7'b0, rbif}, 8'h00);

    // RBIF: settle on 00, read and clear
    tris_stat = 8'hF0; pin_in = 8'h00;
    cyc(3 + XL); pulse_rd();
    rbif_clr = 1'b1; cyc(1); rbif_clr = 1'b0;
    cmp("rbif cleared", {7'b0, rbif}, 8'h00);
    pin_in = 8'h40;
    cyc(2 + XL);
    cmp("rbif before latency", {7'b0, rbif}, 8'h00);
    cyc(1);
    cmp("rbif set", {7'b0, rbif}, 8'h01);
    rd_en = 1'b1; rbif_clr = 1'b1; cyc(1); rd_en = 1'b0; rbif_clr = 1'b0;
    cmp("rbif set wins", {7'b0, rbif}, 8'h01);
    rbif_clr = 1'b1; cyc(1); rbif_clr = 1'b0;
    cmp("rbif clear after read", {7'b0, rbif}, 8'h00);
    cyc(3);
    cmp("rbif stays clear", {7'b0, rbif}, 8'h00);

    // bit 6 as output does not contribute, bit 5 still does
    tris_stat = 8'hB0; pin_in = 8'h00;
    cyc(4 + XL);
    cmp("rbif masked bit", {7'b0, rbif}, 8'h00);
    pin_in = 8'h20;
    cyc(3 + XL);
    cmp("rbif unmasked bit", {7'b0, rbif}, 8'h01);
    pulse_rd();
    rbif_clr = 1'b1; cyc(1); rbif_clr = 1'b0;
    cmp("rbif cleared again", {7'b0, rbif}, 8'h00);

    // INT rising edge
    tris_stat = 8'h01; intedg = 1'b1; pin_in = 8'h00;
    cyc(4 + XL);
    cmp("intf idle", {7'b0, intf}, 8'h00);
    pin_in = 8'h01;
    cyc(2 + XL);
    cmp("intf before latency", {7'b0, intf}, 8'h00);
    cyc(1);
    cmp("intf rising", {7'b0, intf}, 8'h01);
    intf_clr = 1'b1; cyc(1); intf_clr = 1'b0;
    cmp("intf clear", {7'b0, intf}, 8'h00);
    pin_in = 8'h00;
    cyc(4 + XL);
    cmp("intf falling ignored", {7'b0, intf}, 8'h00);
    intedg = 1'b0;
    cyc(2);
    cmp("intedg change no event", {7'b0, intf}, 8'h00);
    pin_in = 8'h01;
    cyc(4 + XL);
    cmp("intf rising ignored", {7'b0, intf}, 8'h00);
    pin_in = 8'h00;
    cyc(2 + XL);
    cmp("intf before falling", {7'b0, intf}, 8'h00);
    cyc(1);
    cmp("intf falling", {7'b0, intf}, 8'h01);
    intf_clr = 1'b1; cyc(1); intf_clr = 1'b0;
    pin_in = 8'h01;
    cyc(4 + XL);
    pin_in = 8'h00;
    cyc(2 + XL);
    intf_clr = 1'b1; cyc(1); intf_clr = 1'b0;
    cmp("intf set wins", {7'b0, intf}, 8'h01);
    intf_clr = 1'b1; cyc(1); intf_clr = 1'b0;
    cmp("intf cleared", {7'b0, intf}, 8'h00);

    // unprimed after reset
    rst = 1'b1; cyc(1); rst = 1'b0;
    tris_stat = 8'hFF; intedg = 1'b0; pin_in = 8'h00;
    cyc(1);
    pin_in = 8'hF0;
    cyc(10);
    cmp("unprimed rbif", {7'b0, rbif}, 8'h00);
    cmp("unprimed intf", {7'b0, intf}, 8'h00);

    // reset in the middle of detection
    pulse_rd();
    intedg = 1'b1;
    pin_in = 8'h01;
    cyc(1);
    rst = 1'b1; cyc(1); rst = 1'b0;
    cmp("mid reset rbif", {7'b0, rbif}, 8'h00);
    cmp("mid reset intf", {7'b0, intf}, 8'h00);
    cmp("mid reset rd_data", rd_data, 8'h00);
    cyc(10);

`ifdef PORT_IN_GLITCH_FILTER_EN
    tris_stat = 8'h01; intedg = 1'b1; pin_in = 8'h00;
    cyc(8);
    intf_clr = 1'b1; cyc(1); intf_clr = 1'b0;
    pin_in = 8'h01; cyc(2); pin_in = 8'h00;
    cyc(10);
    cmp("filter short pulse", {7'b0, intf}, 8'h00);
    pin_in = 8'h01;
    cyc(5);
    cmp("filter before latency", {7'b0, intf}, 8'h00);
    pin_in = 8'h00;
    cyc(1);
    cmp("filter long pulse", {7'b0, intf}, 8'h01);
    cyc(8);
`endif

    cyc(3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
